// File: rtl/hamming_pkg.sv
// Shared definitions for the 38-bit Hamming (32 data + 6 parity) code,
// used by both the encoder and the decoder so the code layout lives in one place.
package hamming_pkg;

  localparam int DATA_W = 32;
  localparam int PAR_W  = 6;
  localparam int CODE_W = 38;

  // Codeword indices holding parity bits (Hamming positions 1,2,4,8,16,32).
  localparam int PAR_IDX [PAR_W] = '{0, 1, 3, 7, 15, 31};

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [PAR_W-1:0]  syn_t;

  typedef struct packed {
    data_t data;
    syn_t  syndrome;
    logic  corrected;
    logic  uncorr;
  } dec_word_t;

  function automatic logic is_parity_idx(input int idx);
    logic hit;
    hit = 1'b0;
    foreach (PAR_IDX[p]) begin
      if (PAR_IDX[p] == idx) hit = 1'b1;
    end
    return hit;
  endfunction

  // Each set bit contributes its position to every syndrome bit that position
  // has set, so XOR-ing the positions of all ones yields the full syndrome.
  function automatic syn_t calc_syndrome(input code_t code);
    syn_t syn;
    syn = '0;
    for (int j = 1; j <= CODE_W; j++) begin
      logic [5:0] idx;
      idx = 6'(j - 1);
      if (code[idx]) syn = syn ^ syn_t'(j);
    end
    return syn;
  endfunction

  function automatic data_t extract_data(input code_t code);
    data_t      d;
    logic [4:0] k;
    d = '0;
    k = '0;
    for (int i = 0; i < CODE_W; i++) begin
      logic [5:0] idx;
      idx = 6'(i);
      if (!is_parity_idx(i)) begin
        d[k] = code[idx];
        k    = k + 5'd1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/hamming_err_counter.sv
// Saturating event counter with a synchronous clear that wins over increment.
module hamming_err_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: default assignment first, so every path assigns cnt_d and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hamming_decoder.sv
// Two-stage Hamming(38,32) decoder: stage 1 registers codeword + syndrome,
// stage 2 corrects, extracts data and holds it under valid/ready backpressure.
module hamming_decoder
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PAR_W-1:0]  out_syndrome,
  output logic              out_corrected,
  output logic              out_uncorr,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  logic      s1_valid_q;
  code_t     s1_code_q;
  syn_t      s1_syn_q;
  logic      out_valid_q;
  dec_word_t out_q, out_d;
  logic      s2_load, in_fire, out_fire;
  logic      syn_in_range;
  code_t     flip_mask;

  assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else if (in_fire) begin
      s1_valid_q <= 1'b1;
    end else if (s2_load) begin
      s1_valid_q <= 1'b0;
    end
  end

  // NOTE: pure datapath registers carry no reset; s1_valid_q gates them.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_code_q <= in_code;
      s1_syn_q  <= calc_syndrome(in_code);
    end
  end

  // Syndromes 1..38 name a codeword position; anything above is uncorrectable.
  assign syn_in_range = (s1_syn_q != '0) && (s1_syn_q <= syn_t'(CODE_W));
  assign flip_mask    = syn_in_range ? (code_t'(1) << (s1_syn_q - syn_t'(1))) : '0;

  always_comb begin
    out_d           = '0;
    out_d.data      = extract_data(s1_code_q ^ flip_mask);
    out_d.syndrome  = s1_syn_q;
    out_d.corrected = syn_in_range;
    out_d.uncorr    = (s1_syn_q > syn_t'(CODE_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (s2_load) begin
      out_valid_q <= 1'b1;
      out_q       <= out_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_q.data;
  assign out_syndrome  = out_q.syndrome;
  assign out_corrected = out_q.corrected;
  assign out_uncorr    = out_q.uncorr;

  hamming_err_counter #(.CNT_W(CNT_W)) u_corr_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .inc_i (out_fire && out_q.corrected),
    .cnt_o (corr_cnt)
  );

  hamming_err_counter #(.CNT_W(CNT_W)) u_uncorr_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .inc_i (out_fire && out_q.uncorr),
    .cnt_o (uncorr_cnt)
  );

endmodule
